// File: rtl/dfd_cla_match_event_gen_if.sv
// dfd_cla_match_event_gen_if: bundles match flags, qualifier config and event outputs of the CLA match-event qualifier
//   master: drives debug_signals_*_match, evt_enable/mode/polarity/threshold/clear; observes match_event/sticky/run_count/hit_count
//   slave : the qualifier side (inputs/outputs reversed)
interface dfd_cla_match_event_gen_if #(
  parameter int CNT_W     = 16,
  parameter int HIT_CNT_W = 32
);
  logic                 debug_signals_positive_match;
  logic                 debug_signals_negative_match;
  logic                 evt_enable;
  logic [1:0]           evt_mode;
  logic                 evt_polarity;
  logic [CNT_W-1:0]     evt_threshold;
  logic                 evt_clear;
  logic                 match_event;
  logic                 match_sticky;
  logic [CNT_W-1:0]     run_count;
  logic [HIT_CNT_W-1:0] hit_count;
  modport master (
    output debug_signals_positive_match, debug_signals_negative_match, evt_enable, evt_mode,
           evt_polarity, evt_threshold, evt_clear,
    input  match_event, match_sticky, run_count, hit_count
  );
  modport slave (
    input  debug_signals_positive_match, debug_signals_negative_match, evt_enable, evt_mode,
           evt_polarity, evt_threshold, evt_clear,
    output match_event, match_sticky, run_count, hit_count
  );
endinterface

// File: rtl/dfd_cla_match_event_gen.sv
// dfd_cla_match_event_gen: qualifies registered CLA match flags into a level/rising/falling/duration trigger event
//   clock, reset_n : sole clock, asynchronous active-low reset
//   bus (slave)    : match flags + qualifier config in; match_event, match_sticky, run_count, hit_count out (all registered)
//   DFD_CLA_MATCH_EVT_HIT_CNT_EN : when defined, builds the saturating hit counter; otherwise hit_count is tied to 0
module dfd_cla_match_event_gen #(
  parameter int CNT_W     = 16,
  parameter int HIT_CNT_W = 32
) (
  input logic                      clock,
  input logic                      reset_n,
  dfd_cla_match_event_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, FIRED} state_t;
  state_t           state_q, state_d;
  logic             prev_sel_q, prev_sel_d;
  logic             event_q, event_d;
  logic             sticky_q, sticky_d;
  logic [1:0]       mode_q;
  logic             pol_q;
  logic [CNT_W-1:0] run_q, run_d, run_inc, thr_eff, run_dur;
  logic             sel, en, cfg_chg, fire;
  assign sel     = bus.evt_polarity ? bus.debug_signals_negative_match : bus.debug_signals_positive_match;
  assign en      = bus.evt_enable;
  assign cfg_chg = (bus.evt_mode != mode_q) || (bus.evt_polarity != pol_q);
  assign run_inc = &run_q ? run_q : run_q + 1'b1;
  assign thr_eff = (bus.evt_threshold == '0) ? CNT_W'(1) : bus.evt_threshold;
  // duration run length: a fresh run starts at 1 from ARMED, otherwise keeps counting
  assign run_dur = (state_q == ARMED) ? CNT_W'(1) : run_inc;
  // >= rather than == so a threshold lowered mid-run still fires once
  assign fire    = (state_q != FIRED) && (run_dur >= thr_eff);
  always_comb begin
    state_d    = state_q;
    prev_sel_d = sel;
    event_d    = 1'b0;
    run_d      = '0;
    if (bus.evt_clear) state_d = en ? ARMED : IDLE;
    else if (!en) state_d = IDLE;
    else if (state_q == IDLE || cfg_chg) state_d = ARMED;
    else if (bus.evt_mode != 2'd3) begin
      state_d = ARMED;
      run_d   = sel ? run_inc : '0;
      event_d = (bus.evt_mode == 2'd0) ? sel :
                (bus.evt_mode == 2'd1) ? (sel & ~prev_sel_q) : (~sel & prev_sel_q);
    end else if (!sel) state_d = ARMED;
    else begin
      run_d   = run_dur;
      event_d = fire;
      state_d = (fire || state_q == FIRED) ? FIRED : RUN;
    end
    sticky_d = bus.evt_clear ? 1'b0 : (sticky_q | event_d);
  end
`ifdef DFD_CLA_MATCH_EVT_HIT_CNT_EN
  logic [HIT_CNT_W-1:0] hit_q, hit_d;
  // counts the event register, so it trails match_event by one cycle
  assign hit_d = bus.evt_clear ? '0 : (event_q && !(&hit_q)) ? hit_q + 1'b1 : hit_q;
  assign bus.hit_count = hit_q;
`else
  assign bus.hit_count = {HIT_CNT_W{1'b0}};
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      prev_sel_q <= 1'b0;
      event_q    <= 1'b0;
      sticky_q   <= 1'b0;
      run_q      <= '0;
      mode_q     <= 2'd0;
      pol_q      <= 1'b0;
`ifdef DFD_CLA_MATCH_EVT_HIT_CNT_EN
      hit_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_sel_q <= prev_sel_d;
      event_q    <= event_d;
      sticky_q   <= sticky_d;
      run_q      <= run_d;
      mode_q     <= bus.evt_mode;
      pol_q      <= bus.evt_polarity;
`ifdef DFD_CLA_MATCH_EVT_HIT_CNT_EN
      hit_q      <= hit_d;
`endif
    end
  assign bus.match_event  = event_q;
  assign bus.match_sticky = sticky_q;
  assign bus.run_count    = run_q;
endmodule

// File: tb/tb_dfd_cla_match_event_gen.sv
// tb_dfd_cla_match_event_gen: scoreboard bench for the CLA match-event qualifier (CNT_W=4)
module tb_dfd_cla_match_event_gen;
  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  typedef struct {
    int         cyc;
    logic       ev;
    logic       st;
    logic [3:0] rc;
    int         hc;
    string      nm;
  } exp_t;
  exp_t sb[$];
  dfd_cla_match_event_gen_if #(.CNT_W(4), .HIT_CNT_W(32)) bus ();
  dfd_cla_match_event_gen #(.CNT_W(4), .HIT_CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic int hx(input int v);
`ifdef DFD_CLA_MATCH_EVT_HIT_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic set(input logic p, input logic n, input logic e, input logic [1:0] m,
                     input logic pl, input logic [3:0] th, input logic c);
    bus.debug_signals_positive_match = p;
    bus.debug_signals_negative_match = n;
    bus.evt_enable    = e;
    bus.evt_mode      = m;
    bus.evt_polarity  = pl;
    bus.evt_threshold = th;
    bus.evt_clear     = c;
  endtask
  // push the outputs expected after the coming edge, then advance one cycle
  task automatic tick(input logic xev, input logic xst, input logic [3:0] xrc, input int xhc, input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.ev  = xev;
    e.st  = xst;
    e.rc  = xrc;
    e.hc  = hx(xhc);
    e.nm  = nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk({e.nm, ".match_event"}, 32'(bus.match_event), 32'(e.ev));
      chk({e.nm, ".match_sticky"}, 32'(bus.match_sticky), 32'(e.st));
      chk({e.nm, ".run_count"}, 32'(bus.run_count), 32'(e.rc));
      chk({e.nm, ".hit_count"}, bus.hit_count, e.hc);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst.match_event", 32'(bus.match_event), 0);
    chk("rst.match_sticky", 32'(bus.match_sticky), 0);
    chk("rst.run_count", 32'(bus.run_count), 0);
    chk("rst.hit_count", bus.hit_count, 0);
    reset_n = 1'b1;
    // level mode, positive match high for 5 samples
    set(0, 0, 1, 0, 0, 0, 0); tick(0, 0, 0, 0, "lvl_en");
    set(1, 0, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, "lvl1"); tick(1, 1, 2, 1, "lvl2"); tick(1, 1, 3, 2, "lvl3");
    tick(1, 1, 4, 3, "lvl4"); tick(1, 1, 5, 4, "lvl5");
    set(0, 0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 5, "lvl_off"); tick(0, 1, 0, 5, "lvl_off2");
    set(0, 0, 1, 0, 0, 0, 1); tick(0, 0, 0, 0, "clr");
    // rising mode on negative match; enabling with sel already high must not fire
    set(0, 1, 0, 1, 1, 0, 0); tick(0, 0, 0, 0, "dis");
    set(0, 1, 1, 1, 1, 0, 0); tick(0, 0, 0, 0, "rise_en_sel1"); tick(0, 0, 1, 0, "rise_hold");
    set(0, 0, 1, 1, 1, 0, 0); tick(0, 0, 0, 0, "rise_low");
    set(0, 1, 1, 1, 1, 0, 0); tick(1, 1, 1, 0, "rise"); tick(0, 1, 2, 1, "rise_after"); tick(0, 1, 3, 1, "rise_after2");
    // clear in the cycle a rise would fire
    set(0, 0, 1, 1, 1, 0, 0); tick(0, 1, 0, 1, "pre_clr");
    set(0, 1, 1, 1, 1, 0, 1); tick(0, 0, 0, 0, "clr_fire");
    set(0, 0, 1, 1, 1, 0, 0); tick(0, 0, 0, 0, "post_clr");
    set(0, 1, 1, 1, 1, 0, 0); tick(1, 1, 1, 0, "refire");
    set(0, 0, 1, 1, 1, 0, 0); tick(0, 1, 0, 1, "refire_drop");
    // falling mode, then polarity change
    set(0, 0, 1, 2, 1, 0, 0); tick(0, 1, 0, 1, "fall_chg");
    set(0, 1, 1, 2, 1, 0, 0); tick(0, 1, 1, 1, "fall_hi");
    set(0, 0, 1, 2, 1, 0, 0); tick(1, 1, 0, 1, "fall"); tick(0, 1, 0, 2, "fall_after");
    set(1, 0, 1, 2, 0, 0, 0); tick(0, 1, 0, 2, "pol_chg");
    set(0, 0, 1, 2, 0, 0, 0); tick(1, 1, 0, 2, "fall_pos"); tick(0, 1, 0, 3, "fall_pos_after");
    // duration mode, threshold 4
    set(0, 0, 1, 3, 0, 4, 0); tick(0, 1, 0, 3, "dur_chg");
    set(1, 0, 1, 3, 0, 4, 0);
    tick(0, 1, 1, 3, "short1"); tick(0, 1, 2, 3, "short2"); tick(0, 1, 3, 3, "short3");
    set(0, 0, 1, 3, 0, 4, 0); tick(0, 1, 0, 3, "short_drop");
    set(1, 0, 1, 3, 0, 4, 0);
    tick(0, 1, 1, 3, "run1"); tick(0, 1, 2, 3, "run2"); tick(0, 1, 3, 3, "run3");
    tick(1, 1, 4, 3, "dur_fire"); tick(0, 1, 5, 4, "run5"); tick(0, 1, 6, 4, "run6");
    set(0, 0, 1, 3, 0, 4, 0); tick(0, 1, 0, 4, "run_drop");
    // threshold 0 behaves as 1
    set(1, 0, 1, 3, 0, 0, 0); tick(1, 1, 1, 4, "thr0"); tick(0, 1, 2, 5, "thr0_2");
    set(0, 0, 1, 3, 0, 0, 0); tick(0, 1, 0, 5, "thr0_drop");
    // disable mid-run keeps sticky
    set(1, 0, 1, 3, 0, 15, 0);
    tick(0, 1, 1, 5, "pre_dis1"); tick(0, 1, 2, 5, "pre_dis2"); tick(0, 1, 3, 5, "pre_dis3");
    set(1, 0, 0, 3, 0, 15, 0); tick(0, 1, 0, 5, "dis_mid");
    set(1, 0, 1, 3, 0, 15, 0); tick(0, 1, 0, 5, "reen");
    for (int k = 1; k <= 7; k++) tick(0, 1, 4'(k), 5, "to7");
    // asynchronous reset with run_count=7
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.match_event", 32'(bus.match_event), 0);
    chk("arst.match_sticky", 32'(bus.match_sticky), 0);
    chk("arst.run_count", 32'(bus.run_count), 0);
    chk("arst.hit_count", bus.hit_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // saturation of the 4-bit run counter, threshold 15
    tick(0, 0, 0, 0, "rst_reen");
    for (int k = 1; k <= 20; k++) tick(k == 15, k >= 15, (k > 15) ? 4'd15 : 4'(k), (k > 15) ? 1 : 0, "sat");
    set(0, 0, 1, 3, 0, 15, 0); tick(0, 1, 0, 1, "sat_drop");
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("drain.pending", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dfd_cla_match_event_gen.md
# dfd_cla_match_event_gen

Match-event qualifier directly downstream of the CLA debug-signal mask/match stage. Consumes the registered positive/negative match flags and turns them into a qualified trigger event for the CLA trigger/action logic. Supports level, rising-edge, falling-edge and minimum-duration qualification, plus a sticky status bit and a run-length counter. An optional saturating hit counter is available for firmware readout.

## Interface
Parameters:
- CNT_W, 16: width of run-length counter and threshold
- HIT_CNT_W, 32: width of hit counter

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- debug_signals_positive_match  in  1  from mask/match stage (registered)
- debug_signals_negative_match  in  1  from mask/match stage (registered)
- evt_enable  in  1  qualifier enable; level-sensitive
- evt_mode  in  2  0 = level, 1 = rising edge, 2 = falling edge, 3 = duration
- evt_polarity  in  1  0 selects positive match, 1 selects negative match; the selected flag is "sel"
- evt_threshold  in  CNT_W  duration mode: required consecutive sel=1 cycles; 0 is treated as 1
- evt_clear  in  1  single-cycle clear
- match_event  out  1  registered qualified event
- match_sticky  out  1  set by any match_event; held until evt_clear
- run_count  out  CNT_W  current consecutive sel=1 length; saturating
- hit_count  out  HIT_CNT_W  number of match_event cycles (macro-dependent)

## Operation
- Reset values: all outputs 0, state IDLE, prev_sel 0.
- States: IDLE, ARMED, RUN, FIRED.
- IDLE: entered whenever evt_enable=0 (any state, next edge).
  - match_event and run_count are held at 0.
  - match_sticky and hit_count are retained.
  - Exit: IDLE→ARMED when evt_enable=1. On that transition prev_sel loads sel and no event is generated.
- ARMED, modes 0–2: the state machine stays in ARMED. prev_sel updates every cycle.
  - Level: match_event = sel.
  - Rising: match_event = sel & ~prev_sel.
  - Falling: match_event = ~sel & prev_sel.
- Duration mode (3):
  - ARMED→RUN when sel=1; run_count becomes 1.
  - In RUN, each sel=1 cycle increments run_count, saturating at all-ones.
  - When run_count reaches max(evt_threshold,1), match_event pulses once and the state goes to FIRED.
  - FIRED: run_count keeps counting; no further events.
  - Any sel=0 in RUN or FIRED: go to ARMED, run_count → 0.
- run_count is also maintained in modes 0–2: it counts consecutive sel=1 cycles while enabled.
- evt_mode or evt_polarity changed while enabled: the block re-enters ARMED, reloads prev_sel and zeroes run_count; no event that cycle.
- evt_clear (highest priority):
  - Zeroes match_sticky, run_count and hit_count.
  - Suppresses match_event for that cycle.
  - State goes to ARMED if enabled, else IDLE; prev_sel reloads sel.
- hit_count increments on every cycle in which match_event=1 and saturates at all-ones.
- The positive and negative inputs are never assumed complementary. Only the selected flag is used.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency from a sel sample to match_event is 1 cycle (that sample's edge).
  - Level mode: match_event is sel delayed 1 cycle.
  - Edge modes: a 1-cycle pulse the cycle after the transition sample.
- Duration mode with threshold N: match_event is high the cycle after the Nth consecutive sel=1 sample. It fires at most once per run.
- match_sticky rises in the same cycle as the first match_event.
- hit_count updates 1 cycle after match_event.
- reset_n assertion mid-run: all state and outputs clear immediately (asynchronous).
- Release of reset_n is synchronized externally; the block adds no synchronizer.

## Configuration
- DFD_CLA_MATCH_EVT_HIT_CNT_EN defined: the hit_count register and its logic are present, as described above.
- DFD_CLA_MATCH_EVT_HIT_CNT_EN undefined: the hit_count port remains and is tied to 0. No counter flops are built. All other behaviour is unchanged.

## Test plan
- Level mode, polarity 0, positive match high for cycles 10–14: match_event high cycles 11–15, match_sticky=1 from cycle 11, hit_count=5.
- Rising mode, polarity 1, negative match 1→0→1 with the rise at cycle 20: exactly one match_event pulse at cycle 21. No event on enable while sel is already 1.
- Duration mode, threshold 4:
  - sel high for 3 cycles: no event.
  - Then sel high for 6 cycles: a single pulse 1 cycle after the 4th sample; run_count reaches 6, then returns to 0 after sel drops.
  - Threshold 0: behaves as 1.
- evt_clear asserted in the same cycle an event would fire: match_event stays 0, and sticky, run_count and hit_count become 0. A later match fires normally.
- Reset mid-run and disable mid-run:
  - reset_n low with run_count=7: all outputs 0 asynchronously.
  - evt_enable low: state goes to IDLE, sticky is retained.
- run_count saturation with CNT_W=4: 20 consecutive sel=1 cycles leave run_count at 15. With the macro undefined, hit_count stays 0 throughout.
